// File: rtl/button_press_gen_if.sv
// rtl/button_press_gen_if.sv - request handshake and button-line bundle for button_press_gen
interface button_press_gen_if;
  logic       start;
  logic [3:0] press_count;
  logic       ready;
  logic       busy;
  logic       done;
  logic       button;
  logic [3:0] presses_sent;

  // Test/control side drives requests and watches the waveform
  modport master (
    output start, press_count,
    input  ready, busy, done, button, presses_sent
  );

  // Generator side
  modport slave (
    input  start, press_count,
    output ready, busy, done, button, presses_sent
  );
endinterface

// File: rtl/button_press_gen.sv
// rtl/button_press_gen.sv - active-low button waveform generator emitting N presses per request; optional contact bounce under BUTTON_BOUNCE_EN
module button_press_gen #(
  parameter int PRESS_CYCLES   = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int CW             = 16,
  parameter int BOUNCE_TOGGLES = 2
) (
  input logic               Clock,
  input logic               Reset,
  button_press_gen_if.slave bus
);

  // Reject configurations the counters cannot represent
  if (PRESS_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_TOGGLES < 0 ||
      (CW < 32 && ((PRESS_CYCLES - 1) >= (1 << CW) || (GAP_CYCLES - 1) >= (1 << CW)))) begin : g_bad_params
    $error("button_press_gen: illegal timing parameters");
  end

  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

`ifdef BUTTON_BOUNCE_EN
  if (BOUNCE_TOGGLES < 1) begin : g_bad_bounce
    $error("button_press_gen: BOUNCE_TOGGLES must be >= 1 with bounce enabled");
  end
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(2 * BOUNCE_TOGGLES - 1);
  typedef enum logic [2:0] {IDLE, PRESS, GAP, DONE, BOUNCE} state_t;
  // Every press begins with the bounce burst
  localparam state_t ENTRY = BOUNCE;
`else
  typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;
  localparam state_t ENTRY = PRESS;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    remaining;

  // Single FSM: sequencing, timing counter and all registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      cnt              <= '0;
      remaining        <= '0;
      bus.ready        <= 1'b1;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.button       <= 1'b1;
      bus.presses_sent <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.ready <= 1'b0;
            if (bus.press_count == 4'd0) begin
              remaining <= '0;
              state     <= DONE;
              bus.done  <= 1'b1;
            end else begin
              // Press counted on entry; remaining holds presses still to come
              remaining        <= bus.press_count - 4'd1;
              state            <= ENTRY;
              cnt              <= '0;
              bus.busy         <= 1'b1;
              bus.button       <= 1'b0;
              bus.presses_sent <= bus.presses_sent + 4'd1;
            end
          end
        end
`ifdef BUTTON_BOUNCE_EN
        BOUNCE: begin
          // Alternate 0,1 each cycle, then settle into the full low phase
          if (cnt == BOUNCE_LAST) begin
            state      <= PRESS;
            cnt        <= '0;
            bus.button <= 1'b0;
          end else begin
            cnt        <= cnt + CW'(1);
            bus.button <= ~bus.button;
          end
        end
`endif
        PRESS: begin
          if (cnt == PRESS_LAST) begin
            state      <= GAP;
            cnt        <= '0;
            bus.button <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          // Release phase follows every press so the last one is seen ending
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (remaining != 4'd0) begin
              remaining        <= remaining - 4'd1;
              state            <= ENTRY;
              bus.button       <= 1'b0;
              bus.presses_sent <= bus.presses_sent + 4'd1;
            end else begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
          bus.button <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_gen.sv
// tb/tb_button_press_gen.sv - self-checking bench for button_press_gen
module tb_button_press_gen;
  localparam int P  = 4;
  localparam int G  = 4;
  localparam int BT = 2;
`ifdef BUTTON_BOUNCE_EN
  localparam int PER      = 2 * BT + P + G;
  localparam int LOWS_PP  = BT + P;
  localparam int FALLS_PP = BT + 1;
`else
  localparam int PER      = P + G;
  localparam int LOWS_PP  = P;
  localparam int FALLS_PP = 1;
`endif
  localparam int BUDGET = 600;

  typedef struct {
    int n;
    bit glitch_busy;
    bit glitch_done;
    int exp_len;
    int exp_sent;
  } vec_t;

  typedef struct {
    int len;
    int lows;
    int falls;
    int sent;
  } exp_t;

  logic Clock;
  logic Reset;
  button_press_gen_if bus ();

  button_press_gen #(
    .PRESS_CYCLES(P),
    .GAP_CYCLES(G),
    .CW(16),
    .BOUNCE_TOGGLES(BT)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  exp_t sbq[$];
  vec_t vecs[5];
  int total;
  int bad;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.press_count = 4'd0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  // Issue one request, then measure the waveform until done and score it
  task automatic run_req(input int n, input bit gb, input bit gd, input int exp_len, input int exp_sent);
    int waitc;
    int len;
    int lows;
    int falls;
    logic prevb;
    exp_t e;
    exp_t got;
    waitc = 0;
    while (!bus.ready && waitc < 100) begin
      @(negedge Clock);
      waitc++;
    end
    check("ready_before_start", int'(bus.ready), 1);
    bus.start = 1'b1;
    bus.press_count = 4'(n);
    e.len = exp_len;
    e.lows = n * LOWS_PP;
    e.falls = n * FALLS_PP;
    e.sent = exp_sent;
    sbq.push_back(e);
    @(negedge Clock);
    bus.start = 1'b0;
    bus.press_count = 4'(n + 5);
    len = 0;
    lows = 0;
    falls = 0;
    prevb = 1'b1;
    while (!bus.done && len < BUDGET) begin
      if (!bus.button) begin
        lows++;
        if (prevb) falls++;
      end
      prevb = bus.button;
      if (gb && len == 2) begin
        bus.start = 1'b1;
        bus.press_count = 4'd9;
      end
      if (len == 3) bus.start = 1'b0;
      @(negedge Clock);
      len++;
    end
    check("done_seen", int'(bus.done), 1);
    if (sbq.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      got = sbq.pop_front();
      check("busy_length", len, got.len);
      check("low_cycles", lows, got.lows);
      check("falling_edges", falls, got.falls);
      check("presses_sent", int'(bus.presses_sent), got.sent);
      check("done_ready_busy_button", int'({bus.ready, bus.busy, bus.button}), 3'b001);
    end
    if (gd) begin
      bus.start = 1'b1;
      bus.press_count = 4'd4;
    end
    @(negedge Clock);
    bus.start = 1'b0;
    check("after_done_rdy_busy_done", int'({bus.ready, bus.busy, bus.done}), 3'b100);
    @(negedge Clock);
    check("no_reaccept_rdy_busy", int'({bus.ready, bus.busy, bus.button}), 3'b101);
  endtask

  initial begin
    int dones;
    int lowseen;
    total = 0;
    bad = 0;
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.press_count = 4'd0;

    vecs[0] = '{3, 1'b0, 1'b0, 3 * PER, 3};
    vecs[1] = '{0, 1'b0, 1'b0, 0, 3};
    vecs[2] = '{1, 1'b1, 1'b0, PER, 4};
    vecs[3] = '{2, 1'b1, 1'b1, 2 * PER, 6};
    vecs[4] = '{15, 1'b0, 1'b0, 15 * PER, 5};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("idle_outputs", int'({bus.button, bus.ready, bus.busy, bus.done, bus.presses_sent}), 8'b1100_0000);
      @(negedge Clock);
    end

    for (int i = 0; i < 5; i++)
      run_req(vecs[i].n, vecs[i].glitch_busy, vecs[i].glitch_done, vecs[i].exp_len, vecs[i].exp_sent);

    // Wrap of the cumulative press counter: 18 presses from reset
    do_reset();
    for (int i = 0; i < 6; i++)
      run_req(3, 1'b0, 1'b0, 3 * PER, (3 * (i + 1)) % 16);
    check("wrap_final", int'(bus.presses_sent), 2);

    // Asynchronous reset in the middle of the second press of five
    bus.start = 1'b1;
    bus.press_count = 4'd5;
    @(negedge Clock);
    bus.start = 1'b0;
    repeat (PER + 1) @(negedge Clock);
    check("second_press_count", int'(bus.presses_sent), 4);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_outputs", int'({bus.button, bus.ready, bus.busy, bus.done, bus.presses_sent}), 8'b1100_0000);
    @(negedge Clock);
    Reset = 1'b0;
    dones = 0;
    lowseen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (bus.done) dones++;
      if (!bus.button) lowseen++;
    end
    check("no_done_after_reset", dones, 0);
    check("no_press_after_reset", lowseen, 0);
    run_req(2, 1'b0, 1'b0, 2 * PER, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
